// File: rtl/phase_sequencer.sv
// Four-phase, multi-round sequencer that drives an external regressive seconds counter.
// Periods and round count are captured at start, so the inputs may change freely mid-sequence.
module phase_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        pause,
    input  logic        abort,
    input  logic [15:0] phase_periods,
    input  logic [3:0]  num_rounds,
    input  logic        timer_finished,
    output logic [3:0]  timer_period,
    output logic        timer_start,
    output logic        timer_reset,
    output logic [1:0]  phase_index,
    output logic [3:0]  rounds_left,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_nxt;
    logic [15:0] periods_q, periods_nxt;
    logic [1:0]  phase_q, phase_nxt;
    logic [3:0]  rounds_q, rounds_nxt;
    logic        fin_prev_q;
    logic        fin_rise;
    logic [3:0]  cur_period;

    assign fin_rise    = timer_finished & ~fin_prev_q;
    assign cur_period  = periods_q[{phase_q, 2'b00} +: 4];
    assign phase_index = phase_q;
    assign rounds_left = rounds_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            periods_q  <= 16'd0;
            phase_q    <= 2'd0;
            rounds_q   <= 4'd0;
            fin_prev_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            periods_q <= periods_nxt;
            phase_q   <= phase_nxt;
            rounds_q  <= rounds_nxt;
            // Cleared on reload so a finished flag left over from the previous phase cannot fire early.
            fin_prev_q <= (state_q == S_LOAD) ? 1'b0 : timer_finished;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        periods_nxt  = periods_q;
        phase_nxt    = phase_q;
        rounds_nxt   = rounds_q;
        timer_period = cur_period;
        timer_start  = 1'b0;
        timer_reset  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy         = 1'b0;
                timer_reset  = 1'b1;
                timer_period = 4'd0;
                if (go && (num_rounds != 4'd0)) begin
                    periods_nxt = phase_periods;
                    rounds_nxt  = num_rounds;
                    phase_nxt   = 2'd0;
                    state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                timer_reset = 1'b1;
                state_nxt   = (cur_period != 4'd0) ? S_RUN : S_NEXT;
            end
            S_RUN: begin
                timer_start = 1'b1;
                if (fin_rise) begin
                    state_nxt = S_NEXT;
                end else if (pause) begin
                    state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (fin_rise) begin
                    state_nxt = S_NEXT;
                end else if (!pause) begin
                    state_nxt = S_RUN;
                end
            end
            S_NEXT: begin
                if (phase_q != 2'd3) begin
                    phase_nxt = phase_q + 2'd1;
                    state_nxt = S_LOAD;
                end else if (rounds_q > 4'd1) begin
                    rounds_nxt = rounds_q - 4'd1;
                    phase_nxt  = 2'd0;
                    state_nxt  = S_LOAD;
                end else begin
                    rounds_nxt = 4'd0;
                    state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                phase_nxt = 2'd0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort outranks every transition above, including a coincident finish.
        if (abort && (state_q != S_IDLE)) begin
            state_nxt  = S_IDLE;
            phase_nxt  = 2'd0;
            rounds_nxt = 4'd0;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a behavioural seconds counter (one tick per cycle) plus a
// phase-list model that predicts RUN periods, round numbers and completion time.
module tb_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] phase_periods = 16'd0;
    logic [3:0]  num_rounds = 4'd0;
    logic        timer_finished;
    logic [3:0]  timer_period;
    logic        timer_start;
    logic        timer_reset;
    logic [1:0]  phase_index;
    logic [3:0]  rounds_left;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    phase_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .go             (go),
        .pause          (pause),
        .abort          (abort),
        .phase_periods  (phase_periods),
        .num_rounds     (num_rounds),
        .timer_finished (timer_finished),
        .timer_period   (timer_period),
        .timer_start    (timer_start),
        .timer_reset    (timer_reset),
        .phase_index    (phase_index),
        .rounds_left    (rounds_left),
        .busy           (busy),
        .done           (done),
        .state_dbg      (state_dbg)
    );

    always #5 clock = ~clock;

    // Regressive counter environment; force_en lets a test inject a finish edge directly.
    logic [3:0] cnt = 4'd0;
    logic       cnt_fin = 1'b0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;

    always @(posedge clock) begin
        if (timer_reset) begin
            cnt     <= timer_period;
            cnt_fin <= 1'b0;
        end else if (timer_start) begin
            if (cnt > 4'd1) begin
                cnt <= cnt - 4'd1;
            end else begin
                cnt     <= 4'd0;
                cnt_fin <= 1'b1;
            end
        end
    end

    assign timer_finished = force_en ? force_val : cnt_fin;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] obs_periods[$];
    logic [3:0] obs_rounds[$];
    logic [1:0] obs_phase[$];
    int         obs_loads, obs_done, obs_done_k, obs_first_start;
    logic       obs_finished;
    logic [3:0] obs_rl_done;

    logic [3:0] exp_q[$];
    logic [3:0] exp_rl[$];
    logic [1:0] exp_ph[$];

    // A phase of period p costs LOAD + (p+1) RUN cycles + NEXT, or LOAD + NEXT when skipped.
    function automatic int build_expect(input logic [15:0] per, input logic [3:0] nr);
        int t;
        logic [3:0] p;
        t = 0;
        exp_q.delete();
        exp_rl.delete();
        exp_ph.delete();
        for (int r = 0; r < int'(nr); r++) begin
            for (int i = 0; i < 4; i++) begin
                p = per[i*4 +: 4];
                if (p == 4'd0) begin
                    t = t + 2;
                end else begin
                    t = t + int'(p) + 3;
                    exp_q.push_back(p);
                    exp_rl.push_back(4'(int'(nr) - r));
                    exp_ph.push_back(2'(i));
                end
            end
        end
        return t;
    endfunction

    task automatic run_seq(input logic [15:0] per, input logic [3:0] nr, input int budget);
        logic prev_start;
        obs_periods.delete();
        obs_rounds.delete();
        obs_phase.delete();
        obs_loads = 0;
        obs_done = 0;
        obs_done_k = -1;
        obs_first_start = -1;
        obs_finished = 1'b0;
        obs_rl_done = 4'hf;
        prev_start = 1'b0;
        @(negedge clock);
        go = 1'b1;
        phase_periods = per;
        num_rounds = nr;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (k == 0) begin
                go = 1'b0;
                phase_periods = 16'($urandom);
                num_rounds = 4'($urandom);
            end
            if (!busy) begin
                obs_finished = 1'b1;
                break;
            end
            if (timer_reset) obs_loads++;
            if (timer_start && !prev_start) begin
                obs_periods.push_back(timer_period);
                obs_rounds.push_back(rounds_left);
                obs_phase.push_back(phase_index);
                if (obs_first_start < 0) obs_first_start = k;
            end
            prev_start = timer_start;
            if (done) begin
                obs_done++;
                obs_done_k = k;
                obs_rl_done = rounds_left;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run += 7;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        if (phase_index !== 2'd0) begin tests_failed++; $display("FAIL reset_phase got=%0d exp=0", phase_index); end
        if (rounds_left !== 4'd0) begin tests_failed++; $display("FAIL reset_rounds got=%0d exp=0", rounds_left); end
        if (timer_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tstart got=%b exp=0", timer_start); end
        if (timer_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_treset got=%b exp=1", timer_reset); end
        if (timer_period !== 4'd0) begin tests_failed++; $display("FAIL reset_tperiod got=%0d exp=0", timer_period); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int t;
        t = build_expect(16'h4213, 4'd1);
        run_seq(16'h4213, 4'd1, t + 10);
        tests_run += 6;
        if (obs_finished !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_fall got=%b exp=1", obs_finished); end
        if (obs_done != 1) begin tests_failed++; $display("FAIL basic_done_count got=%0d exp=1", obs_done); end
        if (obs_done_k != t) begin tests_failed++; $display("FAIL basic_done_cycle got=%0d exp=%0d", obs_done_k, t); end
        if (obs_loads != 4) begin tests_failed++; $display("FAIL basic_load_cycles got=%0d exp=4", obs_loads); end
        if (obs_first_start != 1) begin tests_failed++; $display("FAIL basic_start_latency got=%0d exp=1", obs_first_start); end
        if (obs_periods.size() != exp_q.size()) begin tests_failed++; $display("FAIL basic_run_count got=%0d exp=%0d", obs_periods.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_periods.size() <= i || obs_periods[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_period[%0d] got=%0d exp=%0d", i, (obs_periods.size() > i) ? obs_periods[i] : 4'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_two_rounds();
        int t;
        t = build_expect(16'h1111, 4'd2);
        run_seq(16'h1111, 4'd2, t + 10);
        tests_run += 4;
        if (obs_periods.size() != 8) begin tests_failed++; $display("FAIL two_rounds_runs got=%0d exp=8", obs_periods.size()); end
        if (obs_rl_done !== 4'd0) begin tests_failed++; $display("FAIL two_rounds_rl_done got=%0d exp=0", obs_rl_done); end
        if (obs_done != 1) begin tests_failed++; $display("FAIL two_rounds_done got=%0d exp=1", obs_done); end
        if (obs_done_k != t) begin tests_failed++; $display("FAIL two_rounds_done_cycle got=%0d exp=%0d", obs_done_k, t); end
        for (int i = 0; i < exp_rl.size(); i++) begin
            tests_run++;
            if (obs_rounds.size() <= i || obs_rounds[i] !== exp_rl[i]) begin
                tests_failed++;
                $display("FAIL two_rounds_rl[%0d] got=%0d exp=%0d", i, (obs_rounds.size() > i) ? obs_rounds[i] : 4'hx, exp_rl[i]);
            end
        end
    endtask

    task automatic test_zero_skip();
        int t;
        t = build_expect(16'h3020, 4'd1);
        run_seq(16'h3020, 4'd1, t + 10);
        tests_run += 3;
        if (obs_done_k != t) begin tests_failed++; $display("FAIL zero_done_cycle got=%0d exp=%0d", obs_done_k, t); end
        if (obs_done != 1) begin tests_failed++; $display("FAIL zero_done got=%0d exp=1", obs_done); end
        if (obs_periods.size() != exp_q.size()) begin tests_failed++; $display("FAIL zero_run_count got=%0d exp=%0d", obs_periods.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_periods.size() <= i || obs_periods[i] !== exp_q[i] || obs_phase[i] !== exp_ph[i]) begin
                tests_failed++;
                $display("FAIL zero_run[%0d] got_period=%0d exp=%0d", i, (obs_periods.size() > i) ? obs_periods[i] : 4'hx, exp_q[i]);
            end
        end
        // All-zero periods: eight cycles per round, one done pulse.
        t = build_expect(16'h0000, 4'd2);
        run_seq(16'h0000, 4'd2, t + 10);
        tests_run += 2;
        if (obs_done_k != 16) begin tests_failed++; $display("FAIL allzero_done_cycle got=%0d exp=16", obs_done_k); end
        if (obs_done != 1 || obs_periods.size() != 0) begin tests_failed++; $display("FAIL allzero_shape got_done=%0d got_runs=%0d exp=1/0", obs_done, obs_periods.size()); end
    endtask

    task automatic test_random();
        logic [15:0] per;
        logic [3:0]  nr;
        int          t;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 4; i++) per[i*4 +: 4] = 4'($urandom_range(0, 4));
            nr = 4'($urandom_range(1, 3));
            t = build_expect(per, nr);
            run_seq(per, nr, t + 10);
            tests_run += 4;
            if (obs_done_k != t) begin tests_failed++; $display("FAIL rand%0d_done_cycle per=%h nr=%0d got=%0d exp=%0d", it, per, nr, obs_done_k, t); end
            if (obs_done != 1) begin tests_failed++; $display("FAIL rand%0d_done_count got=%0d exp=1", it, obs_done); end
            if (obs_loads != 4 * int'(nr)) begin tests_failed++; $display("FAIL rand%0d_loads got=%0d exp=%0d", it, obs_loads, 4 * int'(nr)); end
            if (obs_periods.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_runs got=%0d exp=%0d", it, obs_periods.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_periods.size() <= i || obs_periods[i] !== exp_q[i] ||
                    obs_rounds[i] !== exp_rl[i] || obs_phase[i] !== exp_ph[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_run[%0d] per=%h got_period=%0d exp=%0d", it, i, per,
                             (obs_periods.size() > i) ? obs_periods[i] : 4'hx, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_pause();
        int bad;
        int dones;
        @(negedge clock);
        go = 1'b1; phase_periods = 16'h0008; num_rounds = 4'd1;
        @(negedge clock);
        go = 1'b0;
        repeat (2) @(negedge clock);
        pause = 1'b1;
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (timer_start !== 1'b0 || timer_period !== 4'd8 || phase_index !== 2'd0 || busy !== 1'b1) bad++;
            if (i == 5) pause = 1'b0;
        end
        tests_run += 2;
        if (bad != 0) begin tests_failed++; $display("FAIL pause_hold bad_cycles=%0d exp=0", bad); end
        @(negedge clock);
        if (timer_start !== 1'b1) begin tests_failed++; $display("FAIL pause_resume got=%b exp=1", timer_start); end
        dones = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        tests_run += 2;
        if (dones != 1) begin tests_failed++; $display("FAIL pause_done got=%0d exp=1", dones); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL pause_idle got=%b exp=0", busy); end
    endtask

    task automatic test_pause_rise();
        @(negedge clock);
        go = 1'b1; phase_periods = 16'h0055; num_rounds = 4'd1;
        @(negedge clock);
        go = 1'b0;
        @(negedge clock);
        pause = 1'b1; force_en = 1'b1; force_val = 1'b1;
        @(negedge clock);
        force_en = 1'b0;
        tests_run += 3;
        if (timer_start !== 1'b0) begin tests_failed++; $display("FAIL pr_next_start got=%b exp=0", timer_start); end
        @(negedge clock);
        if (timer_reset !== 1'b1 || phase_index !== 2'd1) begin tests_failed++; $display("FAIL pr_load got_treset=%b got_phase=%0d exp=1/1", timer_reset, phase_index); end
        @(negedge clock);
        @(negedge clock);
        if (timer_start !== 1'b0 || timer_reset !== 1'b0) begin tests_failed++; $display("FAIL pr_paused got_start=%b got_treset=%b exp=0/0", timer_start, timer_reset); end
        force_en = 1'b1; force_val = 1'b1;
        @(negedge clock);
        force_en = 1'b0;
        @(negedge clock);
        tests_run++;
        if (timer_reset !== 1'b1 || phase_index !== 2'd2) begin tests_failed++; $display("FAIL pr_rise_in_pause got_treset=%b got_phase=%0d exp=1/2", timer_reset, phase_index); end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0; pause = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL pr_abort_idle got=%b exp=0", busy); end
    endtask

    task automatic test_abort();
        logic found;
        int   dones;
        int   t;
        @(negedge clock);
        go = 1'b1; phase_periods = 16'h3333; num_rounds = 4'd2;
        @(negedge clock);
        go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (timer_start && phase_index == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (found !== 1'b1) begin tests_failed++; $display("FAIL abort_reach_phase2 got=%b exp=1", found); end
        abort = 1'b1; force_en = 1'b1; force_val = 1'b1;
        @(negedge clock);
        abort = 1'b0; force_en = 1'b0;
        tests_run += 4;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle got=%b exp=0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b exp=0", done); end
        if (phase_index !== 2'd0) begin tests_failed++; $display("FAIL abort_phase got=%0d exp=0", phase_index); end
        if (rounds_left !== 4'd0) begin tests_failed++; $display("FAIL abort_rounds got=%0d exp=0", rounds_left); end
        dones = 0;
        repeat (5) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        tests_run++;
        if (dones != 0) begin tests_failed++; $display("FAIL abort_stays_idle got=%0d exp=0", dones); end
        t = build_expect(16'h3333, 4'd2);
        run_seq(16'h3333, 4'd2, t + 10);
        tests_run += 2;
        if (obs_phase.size() == 0 || obs_phase[0] !== 2'd0) begin tests_failed++; $display("FAIL abort_restart_phase got_runs=%0d exp_phase=0", obs_phase.size()); end
        if (obs_done_k != t || obs_done != 1) begin tests_failed++; $display("FAIL abort_restart_done got=%0d exp=%0d", obs_done_k, t); end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        @(negedge clock);
        go = 1'b1; phase_periods = 16'h0006; num_rounds = 4'd3;
        @(negedge clock);
        go = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1; force_en = 1'b1; force_val = 1'b1; go = 1'b1; pause = 1'b1;
        @(negedge clock);
        tests_run += 3;
        if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got_busy=%b got_done=%b exp=0/0", busy, done); end
        if (phase_index !== 2'd0 || rounds_left !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_regs got_phase=%0d got_rounds=%0d exp=0/0", phase_index, rounds_left); end
        if (timer_start !== 1'b0 || timer_reset !== 1'b1 || timer_period !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_timer got_start=%b got_treset=%b got_period=%0d exp=0/1/0", timer_start, timer_reset, timer_period);
        end
        reset = 1'b0; force_en = 1'b0; pause = 1'b0; num_rounds = 4'd0; go = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (busy !== 1'b0) bad++;
        end
        go = 1'b0;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL go_zero_rounds busy_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_two_rounds();
        test_zero_skip();
        test_random();
        test_pause();
        test_pause_rise();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 go  in  1  request to start a sequence; sampled only in IDLE.
REQ-005 pause  in  1  level; while high, the running phase is held.
REQ-006 abort  in  1  sampled every cycle; returns the block to IDLE.
REQ-007 phase_periods  in  16  four 4-bit periods in seconds: phase0=[3:0] ... phase3=[15:12].
REQ-008 num_rounds  in  4  number of full four-phase rounds to run; 0 is invalid.
REQ-009 timer_finished  in  1  finished flag from the regressive counter.
REQ-010 timer_period  out  4  seconds_period driven to the regressive counter.
REQ-011 timer_start  out  1  counter run enable; low means the counter pauses.
REQ-012 timer_reset  out  1  synchronous reload/clear of the counter.
REQ-013 phase_index  out  2  current phase, 0-3.
REQ-014 rounds_left  out  4  rounds remaining, including the current round.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when all rounds have completed.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN, PAUSED, NEXT and DONE, encoded one state per cycle.
REQ-018 On go=1 with num_rounds!=0, IDLE SHALL latch phase_periods and num_rounds, set phase_index=0, and move to LOAD.
- go with num_rounds=0 is ignored.
- go outside IDLE is ignored.
REQ-019 Changes to phase_periods or num_rounds after the latch SHALL NOT affect the sequence in progress.
REQ-020 LOAD (one cycle) SHALL:
- drive timer_period = latched period[phase_index];
- assert timer_reset=1 and timer_start=0;
- go to RUN if that period is nonzero, else go to NEXT (zero-period phases are skipped).
REQ-021 RUN SHALL drive timer_start=1, timer_reset=0, and hold timer_period stable.
REQ-022 timer_finished SHALL be edge-detected by a registered previous value; rise = timer_finished & ~prev. prev SHALL be cleared in LOAD.
REQ-023 Priority in RUN: abort -> IDLE; else rise -> NEXT; else pause=1 -> PAUSED; else stay in RUN.
REQ-024 PAUSED SHALL drive timer_start=0, timer_reset=0.
- abort -> IDLE;
- else pause=0 -> RUN;
- a rise seen in PAUSED SHALL NOT be lost: go to NEXT.
REQ-025 NEXT (one cycle, timer_start=0) SHALL:
- if phase_index<3: increment phase_index and go to LOAD;
- if phase_index=3 and rounds_left>1: decrement rounds_left, set phase_index=0, go to LOAD;
- if phase_index=3 and rounds_left=1: set rounds_left=0 and go to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-027 Latency:
- go sampled at cycle n -> LOAD at n+1 -> timer_start=1 at n+2;
- rise sampled at cycle c -> NEXT at c+1, LOAD at c+2, RUN at c+3.
REQ-028 abort SHALL take priority in every non-IDLE state.
- It forces IDLE on the next cycle and does not assert done.
- rounds_left and phase_index are cleared to 0.
REQ-029 IDLE SHALL hold timer_reset=1, timer_start=0 and timer_period=0.
REQ-030 With all four periods zero, each round SHALL take 8 cycles (LOAD+NEXT x4), and done SHALL still pulse once.
REQ-031 A simultaneous abort and rise SHALL resolve to abort.
REQ-032 A simultaneous pause and rise SHALL resolve to NEXT.

Reset
REQ-033 reset=1 SHALL force IDLE on the next edge, from any state including mid-phase.
REQ-034 Reset values SHALL be:
- phase_index=0, rounds_left=0, busy=0, done=0;
- timer_start=0, timer_reset=1, timer_period=0;
- edge register=0.
REQ-035 reset SHALL have priority over go, abort and pause.

Verification
REQ-036 periods=3,1,2,4 (phase_periods=16'h4213), num_rounds=1, go pulse:
- timer_period sequence is 3,1,2,4;
- each LOAD shows timer_reset=1 for one cycle;
- done pulses once after the phase-3 rise;
- busy then falls.
REQ-037 num_rounds=2, periods 1,1,1,1:
- rounds_left goes 2->1 after the first phase-3 rise, then 0 at DONE;
- exactly 8 RUN phases are observed.
REQ-038 pause=1 held for 5 cycles mid-RUN:
- timer_start=0 for those cycles;
- timer_period and phase_index unchanged;
- RUN resumes one cycle after pause falls.
REQ-039 periods 0,2,0,3, num_rounds=1:
- phases 0 and 2 produce no RUN cycles;
- timer_period takes only the values 2 then 3 in RUN.
REQ-040 abort during phase 2 of round 1:
- IDLE on the next cycle, no done pulse;
- phase_index=0, rounds_left=0;
- a subsequent go restarts from phase 0.
REQ-041 reset asserted mid-RUN with rise on the same cycle, and go with num_rounds=0:
- reset wins, outputs take reset values;
- go with num_rounds=0 leaves busy=0.
